// File: rtl/mul_256b_seq_ctrl.sv
// mul_256b_seq_ctrl: drives one 64x64 multiplier through 16 limb products to form a 256x256 -> 512-bit product.
module mul_256b_seq_ctrl #(
  parameter int MUL_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [255:0] a_i,
  input  logic [255:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [511:0] r_o,
  output logic         mul_vld_o,
  output logic [63:0]  mul_a_o,
  output logic [63:0]  mul_b_o,
  input  logic [127:0] mul_r_i
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state;
  logic [255:0] a_q, b_q;
  logic [511:0] acc, term;
  logic [3:0] kk, kn;
  logic [MUL_LAT-1:0] pv;
  logic [3:0] pk [MUL_LAT];
  logic [2:0] sh;
  logic last;
  always_comb begin
    kn = kk + 4'd1;
    sh = {1'b0, pk[MUL_LAT-1][3:2]} + {1'b0, pk[MUL_LAT-1][1:0]};
    term = {384'b0, mul_r_i} << {sh, 6'b0};
    last = pv[MUL_LAT-1] && pk[MUL_LAT-1] == 4'd15;
  end
  // pv/pk follow the issued {valid, k} so each return lands on its own limb weight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      kk <= '0;
      pv <= '0;
      for (int n = 0; n < MUL_LAT; n++) pk[n] <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      r_o <= '0;
      mul_vld_o <= 1'b0;
      mul_a_o <= '0;
      mul_b_o <= '0;
    end else begin
      done_o <= 1'b0;
      for (int n = MUL_LAT - 1; n > 0; n--) begin
        pv[n] <= pv[n-1];
        pk[n] <= pk[n-1];
      end
      pv[0] <= mul_vld_o;
      pk[0] <= kk;
      if (pv[MUL_LAT-1]) acc <= acc + term;
      case (state)
        IDLE: if (start_i) begin
          a_q <= a_i;
          b_q <= b_i;
          acc <= '0;
          kk <= '0;
          busy_o <= 1'b1;
          mul_vld_o <= 1'b1;
          mul_a_o <= a_i[63:0];
          mul_b_o <= b_i[63:0];
          state <= ISSUE;
        end
        ISSUE: if (kk == 4'd15) begin
          mul_vld_o <= 1'b0;
          mul_a_o <= '0;
          mul_b_o <= '0;
          state <= DRAIN;
        end else begin
          kk <= kn;
          mul_a_o <= a_q[{kn[3:2], 6'b0} +: 64];
          mul_b_o <= b_q[{kn[1:0], 6'b0} +: 64];
        end
        DRAIN: if (last) begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          r_o <= acc + term;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_256b_seq_ctrl.sv
// tb_mul_256b_seq_ctrl: random and directed checks of the 256-bit multiply sequencer at MUL_LAT 1 and 3.
module tb_mul_256b_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start [2];
  logic [255:0] a_in [2], b_in [2];
  logic busy [2], done [2], vld [2];
  logic [511:0] r [2];
  logic [63:0] ma [2], mb [2];
  logic [127:0] mr [2];
  logic [127:0] p0 [3], p1 [3];
  logic [511:0] prev_r [2];
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  mul_256b_seq_ctrl #(.MUL_LAT(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .start_i(start[0]), .a_i(a_in[0]), .b_i(b_in[0]),
    .busy_o(busy[0]), .done_o(done[0]), .r_o(r[0]), .mul_vld_o(vld[0]),
    .mul_a_o(ma[0]), .mul_b_o(mb[0]), .mul_r_i(mr[0])
  );
  mul_256b_seq_ctrl #(.MUL_LAT(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .start_i(start[1]), .a_i(a_in[1]), .b_i(b_in[1]),
    .busy_o(busy[1]), .done_o(done[1]), .r_o(r[1]), .mul_vld_o(vld[1]),
    .mul_a_o(ma[1]), .mul_b_o(mb[1]), .mul_r_i(mr[1])
  );
  // multiplier models: product appears MUL_LAT cycles after operands, unaffected by reset
  always @(posedge clk) begin
    p0[0] <= {64'b0, ma[0]} * {64'b0, mb[0]};
    p1[0] <= {64'b0, ma[1]} * {64'b0, mb[1]};
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end
  assign mr[0] = p0[0];
  assign mr[1] = p1[2];
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction
  task automatic chk_idle(input int u, input logic [511:0] er);
    chk("idle_busy", busy[u], 0);
    chk("idle_done", done[u], 0);
    chk("idle_vld", vld[u], 0);
    chk("idle_ma", ma[u], 0);
    chk("idle_mb", mb[u], 0);
    chk("idle_r", r[u], er);
  endtask
  // called at a negedge; returns at the negedge of the done cycle
  task automatic run_op(input int u, input logic [255:0] a, input logic [255:0] b, input bit dup = 0);
    int lt;
    logic [511:0] e;
    lt = u ? 3 : 1;
    e = {256'b0, a} * {256'b0, b};
    start[u] = 1'b1;
    a_in[u] = a;
    b_in[u] = b;
    @(posedge clk);
    for (int n = 0; n <= 16 + lt; n++) begin
      @(negedge clk);
      start[u] = 1'b0;
      if (dup && n == 4) begin
        start[u] = 1'b1;
        a_in[u] = ~a;
        b_in[u] = ~b;
      end
      chk("vld", vld[u], n <= 15);
      chk("mul_a", ma[u], n <= 15 ? a[64*(n/4) +: 64] : 64'd0);
      chk("mul_b", mb[u], n <= 15 ? b[64*(n%4) +: 64] : 64'd0);
      chk("busy", busy[u], n < 16 + lt);
      chk("done", done[u], n == 16 + lt);
      chk("r", r[u], n == 16 + lt ? e : prev_r[u]);
    end
    prev_r[u] = e;
  endtask
  initial begin
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b0;
      a_in[u] = '0;
      b_in[u] = '0;
      prev_r[u] = '0;
    end
    repeat (2) @(negedge clk);
    chk_idle(0, 0);
    chk_idle(1, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(0, 256'd1, 256'd1);
    run_op(0, {256{1'b1}}, {256{1'b1}});
    chk("ones_hi", r[0][511:256], {{255{1'b1}}, 1'b0});
    chk("ones_lo", r[0][255:0], 256'd1);
    run_op(0, 256'd1 << 64, 256'd3 << 192);
    chk("limb_prod", r[0], 512'd3 << 256);
    run_op(0, rnd256(), rnd256(), 1);
    run_op(0, 256'd0, 256'd0);
    for (int t = 0; t < 4; t++) run_op(0, rnd256(), rnd256());
    @(negedge clk);
    // abort mid-operation
    start[0] = 1'b1;
    a_in[0] = rnd256();
    b_in[0] = rnd256();
    @(posedge clk);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      start[0] = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk_idle(0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prev_r[0] = '0;
    prev_r[1] = '0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk_idle(0, 0);
    end
    run_op(0, rnd256(), rnd256());
    @(negedge clk);
    run_op(1, 256'd1 << 255, 256'd2);
    chk("lat3_r", r[1], 512'd1 << 256);
    run_op(1, 256'd5, 256'd7);
    chk("b2b_r", r[1], 512'd35);
    for (int t = 0; t < 2; t++) run_op(1, rnd256(), rnd256());
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mul_256b_seq_ctrl.md
Name: mul_256b_seq_ctrl

Overview:
- Sequencer that drives a single 64x64 full-word multiplier to build a 256x256 -> 512-bit unsigned product.
- Acts as the initiator of the multiplier interface: issues limb operands and strobes, then collects the 128-bit partial products and accumulates them.
- Sits in the SM2 modular-multiplication path, upstream of modular reduction.

Parameters:
- MUL_LAT, 1, fixed cycles from operands presented on mul_a_o/mul_b_o to the matching product on mul_r_i; legal range 1..4.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start_i  in  1  start request; sampled only when busy_o=0
- a_i  in  256  operand A, captured on accepted start
- b_i  in  256  operand B, captured on accepted start
- busy_o  out  1  operation in progress
- done_o  out  1  one-cycle pulse; r_o valid
- r_o  out  512  product A*B, held until next accepted start
- mul_vld_o  out  1  partial-product issue strobe to multiplier
- mul_a_o  out  64  multiplier operand a
- mul_b_o  out  64  multiplier operand b
- mul_r_i  in  128  multiplier product

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clk. All registers clear: state IDLE, busy_o=0, done_o=0, r_o=0, mul_vld_o=0, mul_a_o=0, mul_b_o=0, counters 0, tracking pipe empty.
- Limbs: A = {a3,a2,a1,a0}, B = {b3,b2,b1,b0}, with limb 0 as the LSW (bits 63:0).
- Issue order: k = 0..15, i = k[3:2], j = k[1:0]; issue pair (a_i, b_j).
- States:
  - IDLE: on start_i=1, capture a_i/b_i, clear accumulator, go to ISSUE.
  - ISSUE: 16 consecutive cycles with mul_vld_o=1, one new k per cycle. After k=15, go to DRAIN.
  - DRAIN: wait until the last product is accumulated, then go to IDLE and pulse done_o.
- Operand outputs: mul_a_o/mul_b_o are registered and valid exactly while mul_vld_o=1; otherwise 0.
- Return tracking:
  - The multiplier provides no completion flag. Returns are tracked by a MUL_LAT-deep shift pipe of {valid, k} aligned to the issue strobe.
  - At the edge where the pipe reports valid for k: acc <= acc + (mul_r_i << 64*(i+j)).
  - Adder is full 512-bit with carry propagation; final sum is < 2^512, so no overflow.
- Timing (E0 = edge accepting start):
  - mul_vld_o high during cycles E0+1 .. E0+16 (edge-relative).
  - Last accumulate at edge E0+16+MUL_LAT.
  - At that edge: done_o<=1 for one cycle, busy_o<=0, r_o<=final acc.
  - Total latency 16+MUL_LAT cycles (17 for the default).
- busy_o is 1 from edge E0 until the done edge.
- start_i while busy_o=1 is ignored; operands and r_o are unaffected.
- start_i in the same cycle as done_o=1 is accepted (busy_o is already 0), giving back-to-back operation.
- r_o updates only at done; it is stable between operations, including while busy.
- Reset mid-operation aborts immediately to the reset values. No done_o is generated, and any in-flight products returning later are ignored because the pipe is cleared.
- Operands 0: the full sequence still runs (no early exit); r_o=0.

Test Plan:
- a=1, b=1, start at E0 -> mul_vld_o high for 16 cycles; done_o at E0+17; r_o=1; busy_o high for cycles E0..E0+16.
- a=b=2^256-1 -> r_o upper 256 bits = 0xFFFF...FFFE, lower 256 bits = 0x000...0001.
- a=0x1_0000000000000000 (limb1=1), b=3<<192 (limb3=3) -> r_o = 3<<256. Check mul_a_o/mul_b_o sequence order k=0..15 against limb values.
- start_i pulsed again at E0+5 with different operands -> ignored; r_o and done timing identical to the single-start case.
- rst_n low at E0+8, released at E0+10 -> all outputs 0, no done_o. A new start then produces the correct result with no stale accumulation.
- MUL_LAT=3, a=2^255, b=2 -> done_o at E0+19, r_o=2^256. Assert start_i on the done cycle and verify the second op (a=5, b=7 -> r_o=35) finishes 19 cycles later.
